// File: rtl/hilo_mult_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: default widths,
// FSM state encoding and the req_op encoding driven by the EXE stage.
package hilo_mult_sequencer_pkg;

  localparam int WORD_LEN = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } hilo_state_e;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MFHI  = 3'd3,
    OP_MFLO  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } hilo_op_e;

  // Ops that take part in the stall/accept protocol; code 7 behaves as NOP.
  function automatic logic is_hilo_op(input logic [2:0] op);
    return (op != OP_NOP) && (op != 3'd7);
  endfunction

endpackage

// File: rtl/hilo_mult_sequencer_core.sv
// shift_add_mult_core: radix-2 shift-add datapath, one partial product per
// clock on unsigned magnitudes.
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        load operands, clear accumulator and counter
//   run_i          perform one iteration
//   mcand_i        multiplicand magnitude
//   mplier_i       multiplier magnitude
//   acc_d_o        accumulator value after the current iteration
//   last_o         current iteration is the final one
module shift_add_mult_core #(
  parameter int WORD_LEN = 32,
  parameter int CNT_W    = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  run_i,
  input  logic [WORD_LEN-1:0]   mcand_i,
  input  logic [WORD_LEN-1:0]   mplier_i,
  output logic [2*WORD_LEN-1:0] acc_d_o,
  output logic                  last_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WORD_LEN - 1);

  logic [2*WORD_LEN-1:0] acc_q;
  logic [2*WORD_LEN-1:0] mcand_q;
  logic [WORD_LEN-1:0]   mplier_q;
  logic [CNT_W-1:0]      cnt_q;

  assign acc_d_o = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last_o  = (cnt_q == LastCnt);

  // mcand_q is shifted once per iteration, so it always equals mcand << cnt.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= {{WORD_LEN{1'b0}}, mcand_i};
      mplier_q <= mplier_i;
      cnt_q    <= '0;
    end else if (run_i) begin
      acc_q    <= acc_d_o;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/hilo_mult_sequencer.sv
// hilo_mult_sequencer: EXE-stage multiply controller owning the HI/LO pair.
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_valid_i       HI/LO-class op presented this cycle
//   req_op_i          hilo_op_e encoding
//   val1_i, val2_i    multiplicand (also MTHI/MTLO source), multiplier
//   flush_i           squash an in-flight multiply
//   stall_o           combinational pipeline hold
//   busy_o, done_o    registered status; done_o pulses when HI/LO take a product
//   rd_data_o         combinational MFHI/MFLO read data
//   hi_o, lo_o        architectural HI/LO
//
// state | meaning
// IDLE  | unit free, all ops proceed
// RUN   | WORD_LEN shift-add iterations, every op stalls
// DONE  | product in HI/LO, one-cycle done pulse; only multiplies stall
module hilo_mult_sequencer
  import hilo_mult_sequencer_pkg::*;
#(
  parameter int WORD_LEN = hilo_mult_sequencer_pkg::WORD_LEN,
  parameter int CNT_W    = hilo_mult_sequencer_pkg::CNT_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  input  logic [2:0]          req_op_i,
  input  logic [WORD_LEN-1:0] val1_i,
  input  logic [WORD_LEN-1:0] val2_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [WORD_LEN-1:0] rd_data_o,
  output logic [WORD_LEN-1:0] hi_o,
  output logic [WORD_LEN-1:0] lo_o
);

  hilo_state_e           state_q, state_d;
  logic [WORD_LEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                  sign_q, sign_d;
  logic                  start, run, last, stall, is_mul;
  logic [WORD_LEN-1:0]   mag1, mag2;
  logic [2*WORD_LEN-1:0] acc_d, prod;

  assign is_mul = req_valid_i && ((req_op_i == OP_MULT) || (req_op_i == OP_MULTU));

  // Unsigned magnitudes: -2**(WORD_LEN-1) negates to itself, which is the
  // correct magnitude when read as unsigned.
  always_comb begin
    mag1 = val1_i;
    mag2 = val2_i;
    if (req_op_i == OP_MULT) begin
      if (val1_i[WORD_LEN-1]) mag1 = -val1_i;
      if (val2_i[WORD_LEN-1]) mag2 = -val2_i;
    end
  end

  assign prod = sign_q ? -acc_d : acc_d;

  shift_add_mult_core #(
    .WORD_LEN (WORD_LEN),
    .CNT_W    (CNT_W)
  ) u_core (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start),
    .run_i    (run),
    .mcand_i  (mag1),
    .mplier_i (mag2),
    .acc_d_o  (acc_d),
    .last_o   (last)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    sign_d    = sign_q;
    start     = 1'b0;
    run       = 1'b0;
    stall     = 1'b0;
    rd_data_o = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (is_mul && !flush_i) begin
          start   = 1'b1;
          sign_d  = (req_op_i == OP_MULT) && (val1_i[WORD_LEN-1] ^ val2_i[WORD_LEN-1]);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        stall = req_valid_i && is_hilo_op(req_op_i);
        run   = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (last) begin
          {hi_d, lo_d} = prod;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        stall   = is_mul;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // MF*/MT* only proceed outside RUN, where they are never stalled.
    if (req_valid_i && !stall && (state_q != ST_RUN)) begin
      unique case (req_op_i)
        OP_MFHI: rd_data_o = hi_q;
        OP_MFLO: rd_data_o = lo_q;
        OP_MTHI: hi_d      = val1_i;
        OP_MTLO: lo_d      = val1_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sign_q  <= sign_d;
    end
  end

  assign stall_o = stall;
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Scoreboard bench for hilo_mult_sequencer: expected HI/LO pairs are queued
// when a multiply is issued and compared when done_o pulses.
module tb_hilo_mult_sequencer;
  import hilo_mult_sequencer_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic [2:0]  req_op_i = OP_NOP;
  logic [31:0] val1_i = '0;
  logic [31:0] val2_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o, busy_o, done_o;
  logic [31:0] rd_data_o, hi_o, lo_o;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  hilo_mult_sequencer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_op_i    (req_op_i),
    .val1_i      (val1_i),
    .val2_i      (val2_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_data_o   (rd_data_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (!sgn) return {32'b0, a} * {32'b0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return 64'(sa * sb);
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid_i = v;
    req_op_i    = op;
    val1_i      = a;
    val2_i      = b;
  endtask

  task automatic mt_op(input logic [2:0] op, input logic [31:0] a);
    @(posedge clk_i); #1;
    drive(1'b1, op, a, 32'h0);
    @(posedge clk_i); #1;
    drive(1'b0, OP_NOP, 32'h0, 32'h0);
  endtask

  // Issue a multiply; hold_op (if not NOP) is presented from RUN cycle 5
  // until the DONE cycle to exercise the stall rules.
  task automatic run_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] hold_op);
    int cyc;
    bit seen;
    logic [63:0] exp;
    logic [31:0] exp_rd;
    @(posedge clk_i); #1;
    drive(1'b1, sgn ? OP_MULT : OP_MULTU, a, b);
    exp_q.push_back(ref_prod(sgn, a, b));
    @(posedge clk_i); #1;
    drive(1'b0, OP_NOP, 32'h0, 32'h0);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      cyc++;
      if (hold_op != OP_NOP && cyc == 5) drive(1'b1, hold_op, 32'h0, 32'h0);
      @(negedge clk_i);
      if (done_o) begin
        seen = 1;
        exp  = exp_q.pop_front();
        check_val("latency", 64'(cyc), 64'd33);
        check_val("hilo", {hi_o, lo_o}, exp);
        if (hold_op != OP_NOP) begin
          exp_rd = (hold_op == OP_MFHI) ? exp[63:32] : (hold_op == OP_MFLO) ? exp[31:0] : 32'h0;
          check_val("done_stall", 64'(stall_o),
                    64'((hold_op == OP_MULT) || (hold_op == OP_MULTU)));
          check_val("done_rd", 64'(rd_data_o), 64'(exp_rd));
        end
      end else if (hold_op != OP_NOP && (cyc == 5 || cyc == 32)) begin
        check_val("run_stall", 64'(stall_o), 64'd1);
      end else if (cyc == 1) begin
        check_val("run_busy", 64'(busy_o), 64'd1);
      end
      @(posedge clk_i); #1;
    end
    drive(1'b0, OP_NOP, 32'h0, 32'h0);
    if (!seen) check_val("done_timeout", 64'd0, 64'd1);
    check_val("idle_after", 64'(busy_o), 64'd0);
  endtask

  // Start a multiply and kill it at RUN cycle 10 with flush or reset.
  task automatic abort_mul(input bit use_rst, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bit seen;
    @(posedge clk_i); #1;
    drive(1'b1, OP_MULT, 32'h0000_0005, 32'h0000_0006);
    @(posedge clk_i); #1;
    drive(1'b0, OP_NOP, 32'h0, 32'h0);
    repeat (9) @(posedge clk_i);
    #1;
    if (use_rst) rst_i = 1'b1;
    else         flush_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i   = 1'b0;
    flush_i = 1'b0;
    check_val(use_rst ? "rst_busy" : "flush_busy", 64'(busy_o), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o) seen = 1;
    end
    check_val(use_rst ? "rst_nodone" : "flush_nodone", 64'(seen), 64'd0);
    check_val(use_rst ? "rst_hilo" : "flush_hilo", {hi_o, lo_o}, {exp_hi, exp_lo});
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_val("rst_busy0", 64'(busy_o), 64'd0);
    check_val("rst_done0", 64'(done_o), 64'd0);
    check_val("rst_hilo0", {hi_o, lo_o}, 64'd0);
    check_val("rst_stall0", 64'(stall_o), 64'd0);

    // 1: MULTU 3x5 with an MFLO waiting through RUN
    run_mul(1'b0, 32'h0000_0003, 32'h0000_0005, OP_MFLO);
    // 2: most-negative corner, back to back; second one holds a MULT into DONE
    run_mul(1'b1, 32'h8000_0000, 32'h8000_0000, OP_NOP);
    run_mul(1'b1, 32'h8000_0000, 32'h0000_0001, OP_MULT);
    // 3/4: -1 x 7 signed with MFHI waiting, then unsigned
    run_mul(1'b1, 32'hFFFF_FFFF, 32'h0000_0007, OP_MFHI);
    run_mul(1'b0, 32'hFFFF_FFFF, 32'h0000_0007, OP_MFLO);
    run_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_NOP);
    for (int i = 0; i < 4; i++)
      run_mul(1'(i), $urandom, $urandom, OP_NOP);

    // flush in IDLE overrides acceptance
    @(posedge clk_i); #1;
    drive(1'b1, OP_MULT, 32'h2, 32'h3);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    drive(1'b0, OP_NOP, 32'h0, 32'h0);
    flush_i = 1'b0;
    check_val("idle_flush_busy", 64'(busy_o), 64'd0);

    // 5: flush mid-RUN keeps MTHI/MTLO values
    mt_op(OP_MTHI, 32'hAAAA_0001);
    mt_op(OP_MTLO, 32'h5555_0002);
    abort_mul(1'b0, 32'hAAAA_0001, 32'h5555_0002);

    // 6: reset mid-RUN clears HI/LO
    abort_mul(1'b1, 32'h0, 32'h0);

    mt_op(OP_MTLO, 32'h0000_1234);
    drive(1'b1, OP_MFLO, 32'h0, 32'h0);
    #1;
    check_val("mflo_idle", 64'(rd_data_o), 64'h1234);
    check_val("mflo_stall", 64'(stall_o), 64'd0);
    drive(1'b1, OP_MFHI, 32'h0, 32'h0);
    #1;
    check_val("mfhi_idle", 64'(rd_data_o), 64'h0);
    drive(1'b0, OP_MFLO, 32'h0, 32'h0);
    #1;
    check_val("rd_novalid", 64'(rd_data_o), 64'h0);
    drive(1'b0, OP_NOP, 32'h0, 32'h0);

    check_val("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
